// File: rtl/pll_mgmt_responder_if.sv
// Avalon-MM management port bundle for the PLL reconfig responder.
// The master drives address/write/read; the slave answers with readdata/waitrequest.
interface pll_mgmt_responder_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
        output mgmt_readdata, mgmt_waitrequest
    );
endinterface

// File: rtl/pll_mgmt_responder.sv
// PLL reconfig management responder: shadow writes, timed apply, active commit.
// Define PLL_MGMT_READBACK_EN to make shadow registers readable over mgmt.
module pll_mgmt_responder #(
    parameter int WR_WAIT      = 2,
    parameter int APPLY_CYCLES = 64
) (
    input  logic                CLK_50M,
    input  logic                RESET,
    pll_mgmt_responder_if.slave mgmt,
    output logic                cfg_mode,
    output logic [17:0]         cfg_n,
    output logic [17:0]         cfg_m,
    output logic [17:0]         cfg_c0,
    output logic [31:0]         cfg_k,
    output logic [3:0]          cfg_bw,
    output logic [2:0]          cfg_cp,
    output logic                cfg_valid,
    output logic                busy,
    output logic                bad_addr
);

    localparam int SW = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
    localparam int AW = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;
    localparam logic [SW-1:0] STALL_LOAD = SW'((WR_WAIT > 0) ? WR_WAIT - 1 : 0);
    localparam logic [AW-1:0] APPLY_LOAD = AW'(APPLY_CYCLES - 1);

    localparam logic [5:0] A_MODE  = 6'd0;
    localparam logic [5:0] A_STAT  = 6'd1;
    localparam logic [5:0] A_START = 6'd2;
    localparam logic [5:0] A_N     = 6'd3;
    localparam logic [5:0] A_M     = 6'd4;
    localparam logic [5:0] A_C0    = 6'd5;
    localparam logic [5:0] A_K     = 6'd7;
    localparam logic [5:0] A_BW    = 6'd8;
    localparam logic [5:0] A_CP    = 6'd9;

    typedef enum logic [1:0] {IDLE, STALL, APPLY} state_t;

    state_t state, state_nxt;

    logic        sh_mode;
    logic [17:0] sh_n, sh_m, sh_c0;
    logic [31:0] sh_k;
    logic [3:0]  sh_bw;
    logic [2:0]  sh_cp;

    logic          poll_mode;
    logic          tail;
    logic [SW-1:0] stall_cnt;
    logic [AW-1:0] apply_cnt;

    logic        stall, wr_acc, rd_acc, shadow_sel;
    logic [5:0]  addr;
    logic [31:0] wd, rd_val;

    assign addr = mgmt.mgmt_address;
    assign wd   = mgmt.mgmt_writedata;

    // poll_mode is latched at start, so a mode write mid-apply takes effect next run
    assign stall  = (state == STALL) || (state == APPLY && !poll_mode);
    assign busy   = (state == APPLY);
    assign wr_acc = mgmt.mgmt_write && !stall;
    assign rd_acc = mgmt.mgmt_read && !mgmt.mgmt_write && !stall;

    assign mgmt.mgmt_waitrequest = stall;

    assign shadow_sel = (addr == A_MODE) || (addr == A_N) || (addr == A_M) ||
                        (addr == A_C0) || (addr == A_K) || (addr == A_BW) ||
                        (addr == A_CP);

    always_ff @(posedge CLK_50M) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (wr_acc && addr == A_START)
                    state_nxt = APPLY;
                else if (wr_acc && shadow_sel && WR_WAIT > 0)
                    state_nxt = STALL;
            end
            STALL: if (stall_cnt == '0) state_nxt = IDLE;
            APPLY: if (tail) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
`ifdef PLL_MGMT_READBACK_EN
        unique case (1'b1)
            addr == A_MODE: rd_val = {31'b0, sh_mode};
            addr == A_STAT: rd_val = {31'b0, ~busy};
            addr == A_N:    rd_val = {14'b0, sh_n};
            addr == A_M:    rd_val = {14'b0, sh_m};
            addr == A_C0:   rd_val = {14'b0, sh_c0};
            addr == A_K:    rd_val = sh_k;
            addr == A_BW:   rd_val = {28'b0, sh_bw};
            addr == A_CP:   rd_val = {29'b0, sh_cp};
            default:        rd_val = '0;
        endcase
`else
        if (addr == A_STAT) rd_val = {31'b0, ~busy};
`endif
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            sh_mode            <= 1'b0;
            sh_n               <= '0;
            sh_m               <= '0;
            sh_c0              <= '0;
            sh_k               <= '0;
            sh_bw              <= '0;
            sh_cp              <= '0;
            cfg_mode           <= 1'b0;
            cfg_n              <= '0;
            cfg_m              <= '0;
            cfg_c0             <= '0;
            cfg_k              <= '0;
            cfg_bw             <= '0;
            cfg_cp             <= '0;
            cfg_valid          <= 1'b0;
            bad_addr           <= 1'b0;
            poll_mode          <= 1'b0;
            tail               <= 1'b0;
            stall_cnt          <= '0;
            apply_cnt          <= '0;
            mgmt.mgmt_readdata <= '0;
        end else begin
            cfg_valid <= 1'b0;
            if (state == IDLE && wr_acc) begin
                stall_cnt <= STALL_LOAD;
                unique case (1'b1)
                    addr == A_MODE: sh_mode <= wd[0];
                    addr == A_STAT: ;
                    addr == A_START: begin
                        apply_cnt <= APPLY_LOAD;
                        tail      <= 1'b0;
                        poll_mode <= sh_mode;
                    end
                    addr == A_N:  sh_n  <= wd[17:0];
                    addr == A_M:  sh_m  <= wd[17:0];
                    addr == A_C0: sh_c0 <= wd[17:0];
                    addr == A_K:  sh_k  <= wd;
                    addr == A_BW: sh_bw <= wd[3:0];
                    addr == A_CP: sh_cp <= wd[2:0];
                    default:      bad_addr <= 1'b1;
                endcase
            end
            if (state == STALL && stall_cnt != '0)
                stall_cnt <= stall_cnt - 1'b1;
            if (state == APPLY) begin
                if (wr_acc && addr == A_MODE)
                    sh_mode <= wd[0];
                // one settle cycle after the count expires before commit
                if (tail) begin
                    tail      <= 1'b0;
                    cfg_valid <= 1'b1;
                    cfg_mode  <= sh_mode;
                    cfg_n     <= sh_n;
                    cfg_m     <= sh_m;
                    cfg_c0    <= sh_c0;
                    cfg_k     <= sh_k;
                    cfg_bw    <= sh_bw;
                    cfg_cp    <= sh_cp;
                end else if (apply_cnt == '0) begin
                    tail <= 1'b1;
                end else begin
                    apply_cnt <= apply_cnt - 1'b1;
                end
            end
            if (rd_acc)
                mgmt.mgmt_readdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Randomized bench for pll_mgmt_responder against a register-map reference model.
// Build with PLL_MGMT_READBACK_EN to match a readback-enabled DUT.
module tb_pll_mgmt_responder;
    localparam int WR_WAIT      = 2;
    localparam int APPLY_CYCLES = 64;
    localparam int LAT          = APPLY_CYCLES + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    pll_mgmt_responder_if mgmt ();

    logic        cfg_mode;
    logic [17:0] cfg_n, cfg_m, cfg_c0;
    logic [31:0] cfg_k;
    logic [3:0]  cfg_bw;
    logic [2:0]  cfg_cp;
    logic        cfg_valid, busy, bad_addr;

    pll_mgmt_responder #(
        .WR_WAIT     (WR_WAIT),
        .APPLY_CYCLES(APPLY_CYCLES)
    ) dut (
        .CLK_50M  (clk),
        .RESET    (rst),
        .mgmt     (mgmt),
        .cfg_mode (cfg_mode),
        .cfg_n    (cfg_n),
        .cfg_m    (cfg_m),
        .cfg_c0   (cfg_c0),
        .cfg_k    (cfg_k),
        .cfg_bw   (cfg_bw),
        .cfg_cp   (cfg_cp),
        .cfg_valid(cfg_valid),
        .busy     (busy),
        .bad_addr (bad_addr)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int valid_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cfg_valid) valid_q.push_back(cyc);

    // reference model: shadow and active contents indexed by register address
    logic [31:0] sh [64];
    logic [31:0] act[64];
    logic        bad_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmask(input int a);
        case (a)
            0:       return 32'h1;
            3, 4, 5: return 32'h3FFFF;
            7:       return 32'hFFFFFFFF;
            8:       return 32'hF;
            9:       return 32'h7;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_mapped(input int a);
        return (a <= 5) || (a == 7) || (a == 8) || (a == 9);
    endfunction

    function automatic logic [31:0] rd_exp(input int a, input bit busy_b);
`ifdef PLL_MGMT_READBACK_EN
        if (a == 1) return {31'b0, !busy_b};
        return sh[a] & fmask(a);
`else
        return (a == 1) ? {31'b0, !busy_b} : 32'h0;
`endif
    endfunction

    task automatic wr(input logic [5:0] a, input logic [31:0] d,
                      output int acc, output logic vld_at_acc);
        int n = 0;
        @(negedge clk);
        mgmt.mgmt_address   = a;
        mgmt.mgmt_writedata = d;
        mgmt.mgmt_write     = 1'b1;
        while (mgmt.mgmt_waitrequest === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("wr_timeout", 32'd1, 32'd0);
        vld_at_acc = cfg_valid;
        @(negedge clk);
        mgmt.mgmt_write = 1'b0;
        acc = cyc;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] q,
                      output int acc, output logic wr_hi);
        int n = 0;
        @(negedge clk);
        mgmt.mgmt_address = a;
        mgmt.mgmt_read    = 1'b1;
        wr_hi = mgmt.mgmt_waitrequest;
        while (mgmt.mgmt_waitrequest === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("rd_timeout", 32'd1, 32'd0);
        @(negedge clk);
        mgmt.mgmt_read = 1'b0;
        acc = cyc;
        q = mgmt.mgmt_readdata;
    endtask

    task automatic model_wr(input int a, input logic [31:0] d);
        if (fmask(a) != 0) sh[a] = d & fmask(a);
        if (!is_mapped(a)) bad_m = 1'b1;
    endtask

    task automatic wait_valid(output int vc);
        int n = 0;
        vc = -1000;
        while (n < LAT + 20) begin
            @(negedge clk);
            n++;
            if (cfg_valid) begin
                vc = cyc;
                break;
            end
        end
    endtask

    task automatic chk_active(input string tag);
        chk({tag, "_mode"}, {31'b0, cfg_mode}, act[0]);
        chk({tag, "_n"}, {14'b0, cfg_n}, act[3]);
        chk({tag, "_m"}, {14'b0, cfg_m}, act[4]);
        chk({tag, "_c0"}, {14'b0, cfg_c0}, act[5]);
        chk({tag, "_k"}, cfg_k, act[7]);
        chk({tag, "_bw"}, {28'b0, cfg_bw}, act[8]);
        chk({tag, "_cp"}, {29'b0, cfg_cp}, act[9]);
    endtask

    task automatic run_apply(input string tag);
        int acc, vc;
        logic v;
        wr(6'd2, $urandom, acc, v);
        wait_valid(vc);
        chk({tag, "_latency"}, vc - acc, LAT);
        for (int i = 0; i < 64; i++) act[i] = sh[i];
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        chk_active(tag);
    endtask

    initial begin
        int acc, acc0, vc, n;
        logic v, wh;
        logic [31:0] q;
        logic [5:0] a;
        logic [31:0] d;
        logic [5:0]  wa[3];
        logic [31:0] wdv[3];

        for (int i = 0; i < 64; i++) begin
            sh[i] = 0;
            act[i] = 0;
        end
        bad_m = 1'b0;
        mgmt.mgmt_address   = '0;
        mgmt.mgmt_write     = 1'b0;
        mgmt.mgmt_writedata = '0;
        mgmt.mgmt_read      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_m", {14'b0, cfg_m}, 0);
        chk("rst_k", cfg_k, 0);
        chk("rst_valid", {31'b0, cfg_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_bad", {31'b0, bad_addr}, 0);
        chk("rst_wait", {31'b0, mgmt.mgmt_waitrequest}, 0);
        chk("rst_rdata", mgmt.mgmt_readdata, 0);

        // directed sequence with stall-length checks after each shadow write
        wa[0] = 6'd4; wdv[0] = 32'h167;
        wa[1] = 6'd7; wdv[1] = 32'hB33332DD;
        wa[2] = 6'd5; wdv[2] = 32'h20302;
        for (int i = 0; i < 3; i++) begin
            wr(wa[i], wdv[i], acc, v);
            model_wr(wa[i], wdv[i]);
            chk("stall_c1", {31'b0, mgmt.mgmt_waitrequest}, 1);
            @(negedge clk);
            chk("stall_c2", {31'b0, mgmt.mgmt_waitrequest}, 1);
            @(negedge clk);
            chk("stall_end", {31'b0, mgmt.mgmt_waitrequest}, 0);
        end
        run_apply("seq");

        // write held during a waitrequest-mode apply lands on the cfg_valid cycle
        wr(6'd2, 32'h0, acc0, v);
        wr(6'd4, 32'h140, acc, v);
        chk("held_at_valid", {31'b0, v}, 1);
        chk("held_acc_cyc", acc - acc0, LAT + 1);
        for (int i = 0; i < 64; i++) act[i] = sh[i];
        model_wr(4, 32'h140);
        chk("held_m_old", {14'b0, cfg_m}, act[4]);
        run_apply("held");

        // polling mode: status reads during apply, ignored restart
        wr(6'd0, 32'h1, acc, v);
        model_wr(0, 32'h1);
        wr(6'd2, 32'h0, acc0, v);
        valid_q.delete();
        n = 0;
        while (cyc < acc0 + LAT + 6) begin
            rd(6'd1, q, acc, wh);
            chk("poll_wait", {31'b0, wh}, 0);
            chk("poll_status", q,
                rd_exp(1, (acc - 1 >= acc0) && (acc - 1 < acc0 + LAT)));
            n++;
            if (n == 5) wr(6'd2, 32'h0, acc, v);
        end
        for (int i = 0; i < 64; i++) act[i] = sh[i];
        chk("poll_valid_cnt", valid_q.size(), 1);
        if (valid_q.size() > 0) chk("poll_valid_cyc", valid_q[0] - acc0, LAT);
        chk_active("poll");

        // unmapped write: sticky error, no stall, no apply
        valid_q.delete();
        wr(6'd6, 32'h55, acc, v);
        model_wr(6, 32'h55);
        chk("bad_set", {31'b0, bad_addr}, 1);
        chk("bad_nostall", {31'b0, mgmt.mgmt_waitrequest}, 0);
        repeat (5) @(negedge clk);
        chk("bad_sticky", {31'b0, bad_addr}, 1);
        chk("bad_novalid", valid_q.size(), 0);

        // N readback
        wr(6'd3, 32'h10000, acc, v);
        model_wr(3, 32'h10000);
        rd(6'd3, q, acc, wh);
        chk("rd_n", q, rd_exp(3, 1'b0));

        // randomized rounds
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 6; k++) begin
                a = 6'($urandom_range(0, 15));
                if (a == 6'd2) a = 6'd3;
                if (a == 6'd15) a = 6'($urandom_range(10, 63));
                d = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    rd(a, q, acc, wh);
                    chk("rnd_rd", q, rd_exp(a, 1'b0));
                end else begin
                    wr(a, d, acc, v);
                    model_wr(a, d);
                end
            end
            run_apply("rnd");
            chk("rnd_bad", {31'b0, bad_addr}, {31'b0, bad_m});
        end

        // reset in the middle of an apply
        wr(6'd0, 32'h0, acc, v);
        wr(6'd2, 32'h0, acc0, v);
        valid_q.delete();
        while (cyc < acc0 + 30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sh[i] = 0;
            act[i] = 0;
        end
        bad_m = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_wait", {31'b0, mgmt.mgmt_waitrequest}, 0);
        chk("abort_bad", {31'b0, bad_addr}, 0);
        chk_active("abort");
        repeat (LAT + 15) @(negedge clk);
        chk("abort_novalid", valid_q.size(), 0);
        rd(6'd3, q, acc, wh);
        chk("abort_rd_n", q, rd_exp(3, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
